// File: rtl/usb4_tx_pkg.sv
// Shared types and ordered-set constants for the USB4 logical-layer lane transmit path.
// Ordered sets are stored MSB-beat-first; per-lane and per-symbol fields are patched in by os_word_f.
package usb4_tx_pkg;

  typedef enum logic [3:0] {
    DSEL_IDLE   = 4'd0,
    DSEL_G3_TS1 = 4'd2,
    DSEL_G3_TS2 = 4'd3,
    DSEL_G4_TS2 = 4'd5,
    DSEL_G4_TS3 = 4'd6,
    DSEL_G4_TS4 = 4'd7,
    DSEL_DATA   = 4'd8,
    DSEL_ZERO   = 4'd9
  } dsel_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OS,
    ST_DATA,
    ST_ZERO
  } tx_state_e;

  localparam int OS_W_MAX = 64;

  localparam logic [63:0] G3_TS1 = 64'h4B00_F0E1_D2C3_B4A5;
  localparam logic [63:0] G3_TS2 = 64'h4D00_A5B4_C3D2_E1F0;
  localparam logic [63:0] G4_TS2 = 64'h7E02_D000_1111_2222;
  localparam logic [63:0] G4_TS3 = 64'h7E03_D000_3333_4444;
  localparam logic [63:0] G4_TS4 = 64'h7E04_D000_0000_5555;

  localparam int LANE_IDX_LSB = 48;
  localparam int LANE_IDX_MSB = 55;
  localparam int SYM_LSB      = 40;
  localparam int SYM_MSB      = 43;
  localparam int SYM_INV_LSB  = 36;
  localparam int SYM_INV_MSB  = 39;

  function automatic logic is_os_sel(input logic [3:0] sel);
    case (sel)
      DSEL_G3_TS1, DSEL_G3_TS2, DSEL_G4_TS2, DSEL_G4_TS3, DSEL_G4_TS4: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Gen3 sets carry the lane number; TS4 carries the symbol count and its complement.
  function automatic logic [63:0] os_word_f(input logic [3:0] sel, input logic [7:0] lane,
                                            input logic [3:0] sym);
    logic [63:0] w;
    w = '0;
    case (sel)
      DSEL_G3_TS1: begin
        w = G3_TS1;
        w[LANE_IDX_MSB:LANE_IDX_LSB] = lane;
      end
      DSEL_G3_TS2: begin
        w = G3_TS2;
        w[LANE_IDX_MSB:LANE_IDX_LSB] = lane;
      end
      DSEL_G4_TS2: w = G4_TS2;
      DSEL_G4_TS3: w = G4_TS3;
      DSEL_G4_TS4: begin
        w = G4_TS4;
        w[SYM_MSB:SYM_LSB]         = sym;
        w[SYM_INV_MSB:SYM_INV_LSB] = ~sym;
      end
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/os_beat_serializer.sv
// Per-lane ordered-set serializer: holds one OS word and presents it LANE_W bits at a time,
// MSB beat first, each beat held BEAT_HOLD cycles; flags the final cycle of the last beat.
module os_beat_serializer #(
  parameter int LANE_W    = 8,
  parameter int OS_W      = 64,
  parameter int BEAT_HOLD = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic [OS_W-1:0]   os_word,
  output logic [LANE_W-1:0] beat,
  output logic              last
);

  localparam int NBEATS = OS_W / LANE_W;
  localparam int BW     = $clog2(NBEATS) + 1;
  localparam int HW     = $clog2(BEAT_HOLD) + 1;

  logic [OS_W-1:0] word_p0;
  logic [OS_W-1:0] shifted;
  logic [BW-1:0]   beat_p0;
  logic [HW-1:0]   hold_p0;
  logic            beat_end;

  assign beat_end = (hold_p0 == HW'(BEAT_HOLD - 1));
  assign last     = beat_end && (beat_p0 == BW'(NBEATS - 1));
  assign shifted  = word_p0 << (int'(beat_p0) * LANE_W);
  assign beat     = shifted[OS_W-1 -: LANE_W];

  // Stage p0: OS word capture
  always_ff @(posedge clk) begin
    if (load) word_p0 <= os_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_p0 <= '0;
      hold_p0 <= '0;
    end else if (load) begin
      beat_p0 <= '0;
      hold_p0 <= '0;
    end else if (advance) begin
      if (beat_end) begin
        hold_p0 <= '0;
        if (!last) beat_p0 <= beat_p0 + BW'(1);
      end else begin
        hold_p0 <= hold_p0 + HW'(1);
      end
    end
  end

endmodule

// File: rtl/os_lane_tx_scheduler.sv
// Multi-lane logical-layer transmit scheduler: ordered-set repeat/serialization per lane,
// striped transport data with valid/ready, and a zero/idle fill, selected by the LTSSM's d_sel.
module os_lane_tx_scheduler
  import usb4_tx_pkg::*;
#(
  parameter int LANES     = 2,
  parameter int LANE_W    = 8,
  parameter int OS_W      = 64,
  parameter int BEAT_HOLD = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              d_sel,
  input  logic [7:0]              os_repeat,
  input  logic [LANES*LANE_W-1:0] tx_data,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  output logic [LANES*LANE_W-1:0] lane_tx,
  output logic                    tx_lanes_on,
  output logic                    os_sent,
  output logic                    os_done
);

  tx_state_e               state_p0, state_nxt;
  logic [3:0]              sel_p0, sel_nxt;
  logic [7:0]              os_cnt_p0, cnt_nxt, cnt_inc;
  logic [3:0]              sym_p0, sym_nxt;
  logic                    os_done_p0, done_nxt;
  logic                    os_sent_p0, sent_nxt;
  logic                    lanes_on_p0, on_nxt;
  logic                    vld_p0;
  logic [LANES*LANE_W-1:0] data_p0;
  logic                    load, advance, redecide, ser_last;
  logic [LANES*LANE_W-1:0] os_beats;
  logic [LANES-1:0]        lane_last;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [OS_W_MAX-1:0] word_full;
    assign word_full = os_word_f(sel_nxt, 8'(i), sym_nxt);
    os_beat_serializer #(
      .LANE_W   (LANE_W),
      .OS_W     (OS_W),
      .BEAT_HOLD(BEAT_HOLD)
    ) u_ser (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .advance(advance),
      .os_word(word_full[OS_W-1:0]),
      .beat   (os_beats[i*LANE_W +: LANE_W]),
      .last   (lane_last[i])
    );
  end

  // All lanes run in lockstep, so any lane's last flag marks the OS boundary.
  assign ser_last = &lane_last;
  assign tx_ready = (state_p0 == ST_DATA) && (d_sel == DSEL_DATA);

  always_comb begin
    state_nxt = state_p0;
    sel_nxt   = sel_p0;
    cnt_nxt   = os_cnt_p0;
    sym_nxt   = sym_p0;
    done_nxt  = os_done_p0;
    sent_nxt  = 1'b0;
    on_nxt    = lanes_on_p0;
    load      = 1'b0;
    advance   = 1'b0;
    redecide  = 1'b0;
    cnt_inc   = sat_inc8(os_cnt_p0);
    case (state_p0)
      ST_IDLE: redecide = 1'b1;
      ST_OS: begin
        if (!os_done_p0) begin
          advance = 1'b1;
          if (ser_last) begin
            sent_nxt = 1'b1;
            on_nxt   = 1'b1;
            if (d_sel != sel_p0) begin
              redecide = 1'b1;
            end else begin
              cnt_nxt = cnt_inc;
              if (sel_p0 == DSEL_G4_TS4) sym_nxt = sat_inc4(sym_p0);
              if ((os_repeat != 8'd0) && (cnt_inc == os_repeat)) done_nxt = 1'b1;
              else load = 1'b1;
            end
          end
        end else if (d_sel != sel_p0) begin
          redecide = 1'b1;
        end
      end
      ST_DATA: redecide = (d_sel != DSEL_DATA);
      ST_ZERO: redecide = (d_sel != DSEL_ZERO);
      default: redecide = 1'b1;
    endcase
    // A new selection always starts with fresh repeat, done and symbol state.
    if (redecide) begin
      sel_nxt  = d_sel;
      cnt_nxt  = 8'd0;
      sym_nxt  = 4'd0;
      done_nxt = 1'b0;
      if (is_os_sel(d_sel)) begin
        state_nxt = ST_OS;
        load      = 1'b1;
      end else if (d_sel == DSEL_DATA) begin
        state_nxt = ST_DATA;
      end else if (d_sel == DSEL_ZERO) begin
        state_nxt = ST_ZERO;
      end else begin
        state_nxt = ST_IDLE;
      end
    end
  end

  // Stage p0: control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0    <= ST_IDLE;
      sel_p0      <= DSEL_IDLE;
      os_cnt_p0   <= 8'd0;
      sym_p0      <= 4'd0;
      os_done_p0  <= 1'b0;
      os_sent_p0  <= 1'b0;
      lanes_on_p0 <= 1'b0;
      vld_p0      <= 1'b0;
    end else begin
      state_p0    <= state_nxt;
      sel_p0      <= sel_nxt;
      os_cnt_p0   <= cnt_nxt;
      sym_p0      <= sym_nxt;
      os_done_p0  <= done_nxt;
      os_sent_p0  <= sent_nxt;
      lanes_on_p0 <= on_nxt;
      vld_p0      <= tx_valid && tx_ready;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_valid && tx_ready) data_p0 <= tx_data;
  end

  always_comb begin
    lane_tx = '0;
    if (vld_p0) lane_tx = data_p0;
    else if ((state_p0 == ST_OS) && !os_done_p0) lane_tx = os_beats;
  end

  assign os_sent     = os_sent_p0;
  assign os_done     = os_done_p0;
  assign tx_lanes_on = lanes_on_p0;

endmodule

// File: tb/tb_os_lane_tx_scheduler.sv
// Scoreboard bench: stimulus pushes per-cycle expected outputs, a negedge monitor pops and compares.
// Instance a uses Gen4 pacing (hold 1), instance b Gen3 pacing (hold 8).
module tb_os_lane_tx_scheduler;

  typedef struct packed {
    logic [15:0] lane;
    logic        rdy;
    logic        sent;
    logic        done;
    logic        on;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, valid_a, ready_a, on_a, sent_a, done_a;
  logic [3:0]  d_sel_a;
  logic [7:0]  rep_a;
  logic [15:0] data_a, lane_a;
  logic        rst_b, valid_b, ready_b, on_b, sent_b, done_b;
  logic [3:0]  d_sel_b;
  logic [7:0]  rep_b;
  logic [15:0] data_b, lane_b;

  exp_t qa[$];
  exp_t qb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic exp_on_a = 1'b0;
  logic exp_on_b = 1'b0;

  os_lane_tx_scheduler #(.LANES(2), .LANE_W(8), .OS_W(64), .BEAT_HOLD(1)) dut_a (
    .clk(clk), .rst(rst_a), .d_sel(d_sel_a), .os_repeat(rep_a), .tx_data(data_a),
    .tx_valid(valid_a), .tx_ready(ready_a), .lane_tx(lane_a), .tx_lanes_on(on_a),
    .os_sent(sent_a), .os_done(done_a)
  );

  os_lane_tx_scheduler #(.LANES(2), .LANE_W(8), .OS_W(64), .BEAT_HOLD(8)) dut_b (
    .clk(clk), .rst(rst_b), .d_sel(d_sel_b), .os_repeat(rep_b), .tx_data(data_b),
    .tx_valid(valid_b), .tx_ready(ready_b), .lane_tx(lane_b), .tx_lanes_on(on_b),
    .os_sent(sent_b), .os_done(done_b)
  );

  localparam logic [63:0] TS2_G4 = 64'h7E02_D000_1111_2222;
  localparam logic [63:0] TS3_G4 = 64'h7E03_D000_3333_4444;

  function automatic logic [63:0] ts4(input logic [3:0] s);
    return {8'h7E, 8'h04, 4'hD, s, ~s, 4'h0, 32'h0000_5555};
  endfunction

  function automatic logic [63:0] ts1_g3(input logic [7:0] lane);
    return {8'h4B, lane, 48'hF0E1_D2C3_B4A5};
  endfunction

  function automatic logic [7:0] byte_of(input logic [63:0] w, input int k);
    logic [63:0] t;
    t = w << (8 * k);
    return t[63:56];
  endfunction

  always @(negedge clk) begin
    exp_t e;
    exp_t g;
    if (qa.size() != 0) begin
      e = qa.pop_front();
      g = {lane_a, ready_a, sent_a, done_a, on_a};
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL dut_a t=%0t got lane=%h rdy=%b sent=%b done=%b on=%b want lane=%h rdy=%b sent=%b done=%b on=%b",
                 $time, g.lane, g.rdy, g.sent, g.done, g.on, e.lane, e.rdy, e.sent, e.done, e.on);
      end
    end
    if (qb.size() != 0) begin
      e = qb.pop_front();
      g = {lane_b, ready_b, sent_b, done_b, on_b};
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL dut_b t=%0t got lane=%h rdy=%b sent=%b done=%b on=%b want lane=%h rdy=%b sent=%b done=%b on=%b",
                 $time, g.lane, g.rdy, g.sent, g.done, g.on, e.lane, e.rdy, e.sent, e.done, e.on);
      end
    end
  end

  task automatic tick_a(input logic [15:0] l, input logic r, input logic s, input logic d);
    qa.push_back({l, r, s, d, exp_on_a});
    @(posedge clk);
    #1;
  endtask

  task automatic tick_b(input logic [15:0] l, input logic r, input logic s, input logic d);
    qb.push_back({l, r, s, d, exp_on_b});
    @(posedge clk);
    #1;
  endtask

  // nb beats of one OS on instance a; d_sel switches to cs at beat cb (cb<0: no switch).
  task automatic os_a(input logic [63:0] w0, input logic [63:0] w1, input logic s1,
                      input int nb, input int cb, input logic [3:0] cs);
    for (int k = 0; k < nb; k++) begin
      if (k == cb) d_sel_a = cs;
      tick_a({byte_of(w1, k), byte_of(w0, k)}, 1'b0, s1 && (k == 0), 1'b0);
    end
  endtask

  task automatic seq_a();
    tick_a(16'h0, 1'b0, 1'b0, 1'b0);
    tick_a(16'h0, 1'b0, 1'b0, 1'b0);
    rst_a = 1'b0;
    // two G4 TS2, then hold with os_done
    d_sel_a = 4'd5;
    rep_a   = 8'd2;
    tick_a(16'h0, 1'b0, 1'b0, 1'b0);
    os_a(TS2_G4, TS2_G4, 1'b0, 8, -1, 4'd0);
    exp_on_a = 1'b1;
    os_a(TS2_G4, TS2_G4, 1'b1, 8, -1, 4'd0);
    tick_a(16'h0, 1'b0, 1'b1, 1'b1);
    tick_a(16'h0, 1'b0, 1'b0, 1'b1);
    d_sel_a = 4'd0;
    tick_a(16'h0, 1'b0, 1'b0, 1'b1);
    // switch to data at beat 3: OS completes first
    d_sel_a = 4'd5;
    rep_a   = 8'd0;
    tick_a(16'h0, 1'b0, 1'b0, 1'b0);
    os_a(TS2_G4, TS2_G4, 1'b0, 8, 3, 4'd8);
    valid_a = 1'b1;
    data_a  = 16'hA55A;
    tick_a(16'h0, 1'b1, 1'b1, 1'b0);
    valid_a = 1'b0;
    tick_a(16'hA55A, 1'b1, 1'b0, 1'b0);
    valid_a = 1'b1;
    tick_a(16'h0, 1'b1, 1'b0, 1'b0);
    data_a = 16'h1234;
    tick_a(16'hA55A, 1'b1, 1'b0, 1'b0);
    valid_a = 1'b0;
    tick_a(16'h1234, 1'b1, 1'b0, 1'b0);
    // leave data: ready drops immediately, offered beat is not taken
    d_sel_a = 4'd7;
    valid_a = 1'b1;
    data_a  = 16'hFFFF;
    tick_a(16'h0, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 20; n++) begin
      logic [3:0] s;
      s = (n > 15) ? 4'd15 : 4'(n);
      os_a(ts4(s), ts4(s), n > 0, 8, (n == 19) ? 5 : -1, 4'd9);
    end
    tick_a(16'h0, 1'b0, 1'b1, 1'b0);
    valid_a = 1'b0;
    tick_a(16'h0, 1'b0, 1'b0, 1'b0);
    // async reset mid-OS, then a full OS from beat 0
    d_sel_a = 4'd6;
    tick_a(16'h0, 1'b0, 1'b0, 1'b0);
    os_a(TS3_G4, TS3_G4, 1'b0, 4, -1, 4'd0);
    rst_a    = 1'b1;
    exp_on_a = 1'b0;
    tick_a(16'h0, 1'b0, 1'b0, 1'b0);
    tick_a(16'h0, 1'b0, 1'b0, 1'b0);
    rst_a = 1'b0;
    tick_a(16'h0, 1'b0, 1'b0, 1'b0);
    os_a(TS3_G4, TS3_G4, 1'b0, 8, 7, 4'd0);
    exp_on_a = 1'b1;
    tick_a(16'h0, 1'b0, 1'b1, 1'b0);
    tick_a(16'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic seq_b();
    tick_b(16'h0, 1'b0, 1'b0, 1'b0);
    rst_b   = 1'b0;
    d_sel_b = 4'd2;
    rep_b   = 8'd1;
    tick_b(16'h0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++)
      for (int h = 0; h < 8; h++)
        tick_b({byte_of(ts1_g3(8'd1), k), byte_of(ts1_g3(8'd0), k)}, 1'b0, 1'b0, 1'b0);
    exp_on_b = 1'b1;
    tick_b(16'h0, 1'b0, 1'b1, 1'b1);
    tick_b(16'h0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst_a = 1'b1; d_sel_a = 4'd0; rep_a = 8'd0; data_a = 16'h0; valid_a = 1'b0;
    rst_b = 1'b1; d_sel_b = 4'd0; rep_b = 8'd0; data_b = 16'h0; valid_b = 1'b0;
    @(posedge clk);
    #1;
    fork
      seq_a();
      seq_b();
    join
    n_tests++;
    if ((qa.size() + qb.size()) != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d pending entries, want 0", qa.size() + qb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
